// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default data width and read-drain FSM states.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    HOLD
  } drain_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular valid/ready buffer: tail push, head pop, occupancy count.
module fifo_rd_skid #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     occ,
  output logic                       valid,
  output logic [DATA_WIDTH-1:0]      data
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [OW-1:0]         occ_q, occ_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q + OW'(push) - OW'(pop);
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ   = occ_q;
  assign valid = (occ_q != '0);
  assign data  = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side FIFO consumer: pops, absorbs read latency, re-streams in order.
// FIFO_RD_STATS_EN adds the rd_count delivered-word counter.
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUF_DEPTH  = 2
`ifdef FIFO_RD_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  idle
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

  localparam int OW = $clog2(BUF_DEPTH) + 1;
  localparam int LW = OW + 1;

  logic          infl_q, infl_d;
  logic [OW-1:0] occ;
  logic          deq;
  logic [LW-1:0] level;
  drain_state_t  state_q, state_d;

  assign deq = out_valid & out_ready;

  // Occupancy after this edge, counting the word already in flight.
  assign level = LW'(occ) + LW'(infl_q) - LW'(deq);

  assign fifo_rd_en = drain_en & ~fifo_empty &
                      (level < LW'(BUF_DEPTH));
  assign infl_d = fifo_rd_en;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (infl_q),
    .push_data (fifo_rd_data),
    .pop       (deq),
    .occ       (occ),
    .valid     (out_valid),
    .data      (out_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fifo_rd_en) state_d = STREAM;
      end
      STREAM: begin
        if (level == '0 && !fifo_rd_en) begin
          state_d = IDLE;
        end else if (level == LW'(BUF_DEPTH) && !out_ready) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (deq) state_d = STREAM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      infl_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      infl_q  <= infl_d;
      state_q <= state_d;
    end
  end

  assign idle = (state_q == IDLE) & fifo_empty;

`ifdef FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (deq) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain with a behavioural registered-read FIFO.
module tb_fifo_rd_drain;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drain_en = 1'b0;
  logic       out_ready = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       idle;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] rd_count;
  logic [7:0]  rd_count8;
  logic        fifo_rd_en8, out_valid8, idle8;
  logic [7:0]  out_data8;
`endif

  logic [7:0] mem [1024];
  int push_cnt = 0;
  int pop_cnt  = 0;
  int checks   = 0;
  int errors   = 0;
  int base;

  always #5 clk = ~clk;

  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_cnt      <= push_cnt;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[pop_cnt % 1024];
      pop_cnt      <= pop_cnt + 1;
    end
  end

  fifo_rd_drain #(
    .DATA_WIDTH (8),
    .BUF_DEPTH  (2)
`ifdef FIFO_RD_STATS_EN
    , .CNT_WIDTH (16)
`endif
  ) dut (
    .rd_clk       (clk),
    .rd_rst       (rst),
    .drain_en     (drain_en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .idle         (idle)
`ifdef FIFO_RD_STATS_EN
    , .rd_count   (rd_count)
`endif
  );

`ifdef FIFO_RD_STATS_EN
  fifo_rd_drain #(
    .DATA_WIDTH (8),
    .BUF_DEPTH  (2),
    .CNT_WIDTH  (8)
  ) dut8 (
    .rd_clk       (clk),
    .rd_rst       (rst),
    .drain_en     (drain_en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en8),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid8),
    .out_ready    (out_ready),
    .out_data     (out_data8),
    .idle         (idle8),
    .rd_count     (rd_count8)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      mem[push_cnt % 1024] = 8'(b + i);
      push_cnt++;
    end
  endtask

  task automatic collect(input string tag, input int n,
                         input logic [7:0] b, input int maxc);
    int got = 0;
    int k = 0;
    while (got < n && k < maxc) begin
      if (out_valid && out_ready) begin
        chk(tag, 32'(out_data), 32'(8'(b + got)));
        got++;
      end
      @(negedge clk);
      k++;
    end
    chk({tag, "_n"}, got, n);
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k = 0;
    while (!idle && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(idle), 1);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_rden", 32'(fifo_rd_en), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_idle", 32'(idle), 1);
    rst = 1'b0;
    @(negedge clk);

    // 1: 8 back-to-back words, 2-cycle latency
    out_ready = 1'b1;
    drain_en  = 1'b1;
    push(8, 8'h11);
    #1;
    chk("t1_pop0", 32'(fifo_rd_en), 1);
    @(negedge clk);
    chk("t1_lat1", 32'(out_valid), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_data", 32'(out_data), 32'(8'h11 + i));
    end
    wait_idle("t1_idle", 10);

    // 2: backpressure fills buffer, then release
    out_ready = 1'b0;
    base = pop_cnt;
    push(5, 8'h21);
    repeat (4) @(negedge clk);
    chk("t2_pops", pop_cnt - base, 2);
    chk("t2_occ", 32'(dut.occ), 2);
    chk("t2_state", 32'(dut.state_q), 32'(HOLD));
    chk("t2_rden", 32'(fifo_rd_en), 0);
    chk("t2_head", 32'(out_data), 32'h21);
    out_ready = 1'b1;
    collect("t2_data", 5, 8'h21, 40);
    wait_idle("t2_idle", 10);

    // 3: empty FIFO
    repeat (3) begin
      @(negedge clk);
      chk("t3_rden", 32'(fifo_rd_en), 0);
      chk("t3_valid", 32'(out_valid), 0);
      chk("t3_idle", 32'(idle), 1);
    end

    // 4: drain_en drops right after the first pop
    base = pop_cnt;
    push(3, 8'h31);
    #1;
    chk("t4_pop0", 32'(fifo_rd_en), 1);
    @(posedge clk);
    #1 drain_en = 1'b0;
    #1;
    chk("t4_nopop", 32'(fifo_rd_en), 0);
    @(negedge clk);
    collect("t4_data", 1, 8'h31, 10);
    repeat (2) @(negedge clk);
    chk("t4_pops", pop_cnt - base, 1);
    chk("t4_state", 32'(dut.state_q), 32'(IDLE));
    chk("t4_idle", 32'(idle), 0);
    drain_en = 1'b1;
    collect("t4_rest", 2, 8'h32, 20);
    wait_idle("t4_idle2", 10);

    // 5: async reset with a buffered and an in-flight word
    out_ready = 1'b0;
    push(5, 8'h41);
    repeat (2) @(negedge clk);
    chk("t5_occ", 32'(dut.occ), 1);
    chk("t5_infl", 32'(dut.infl_q), 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_rden", 32'(fifo_rd_en), 0);
    chk("t5_state", 32'(dut.state_q), 32'(IDLE));
    chk("t5_infl0", 32'(dut.infl_q), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_after", 32'(out_valid), 0);

    // 6: 300 words, counter and its 8-bit wrap
    out_ready = 1'b1;
    push(300, 8'h00);
    collect("t6_data", 300, 8'h00, 1000);
    wait_idle("t6_idle", 10);
`ifdef FIFO_RD_STATS_EN
    chk("t6_cnt16", 32'(rd_count), 300);
    chk("t6_cnt8", 32'(rd_count8), 44);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
